psg_sample_decimator: RTL and testbench
=======================================

// Module: psg_sample_decimator
// PURPOSE
//  Downstream stage for the PSG core. Takes the PSG signed 11-bit mixed `sound` output, one sample per
//  strobe, and box-car averages 2^DECIM_LOG2 samples into one.
//  Left-aligns the result to OUT_W bits and queues it in a small FWFT FIFO.
//  The FIFO feeds the audio sink (I2S/DAC serialiser) through a valid/ready handshake.
// PARAMETERS
//  IN_W            11  input sample width (signed, two's complement)
//  OUT_W           16  output sample width; constraint IN_W <= OUT_W <= IN_W+DECIM_LOG2
//  DECIM_LOG2       8  log2 of decimation ratio (block length N = 2^DECIM_LOG2)
//  FIFO_AW          2  log2 of FIFO depth (default depth 4)
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset; synchronous, active-high
//  in_en      in   1          input strobe; din is sampled only when high
//  din        in   IN_W       signed PSG sample
//  out_valid  out  1          FIFO head holds a sample
//  out_ready  in   1          sink accepts the head; a transfer occurs when out_valid & out_ready
//  dout       out  OUT_W      signed FIFO head sample; holds its value while out_valid & !out_ready
//  fifo_level out  FIFO_AW+1  number of stored samples, 0..2^FIFO_AW
//  overflow   out  1          sticky flag: a completed sample was dropped because the FIFO was full
//  clr_ovf    in   1          clears overflow
// BEHAVIOUR
//  - Reset values: acc=0, cnt=0, FIFO empty, out_valid=0, dout=0, fifo_level=0, overflow=0.
//    rst mid-block discards the partial sum and all queued samples.
//  - Accumulator: signed, width IN_W+DECIM_LOG2; it cannot overflow.
//    cnt is DECIM_LOG2 bits wide.
//  - On in_en with cnt != N-1: acc += sext(din); cnt += 1.
//  - On in_en with cnt == N-1:
//      - sum = acc + din; sample = sum[IN_W+DECIM_LOG2-1 -: OUT_W]
//        (arithmetic shift right by IN_W+DECIM_LOG2-OUT_W, truncating toward -inf).
//      - acc <= 0; cnt wraps to 0; sample registered with push pending.
//  - Push latency: the sample enters the FIFO on the cycle after the block's last in_en.
//    out_valid rises that cycle if the FIFO was empty, so dout is valid 1 cycle after the last input.
//  - in_en while a push is pending: accepted normally; no back-pressure toward the PSG.
//  - FIFO: first-word-fall-through. dout = head entry.
//    Pop on out_valid & out_ready. Read/write pointers are FIFO_AW+1 bits and wrap mod 2^(FIFO_AW+1).
//  - Push when full with no pop that cycle: the sample is dropped, FIFO contents are unchanged,
//    and overflow is set.
//  - Push and pop in the same cycle when full: both occur, the sample is accepted and fifo_level stays.
//  - Push and pop in the same cycle when fifo_level==1: the new sample becomes the head next cycle
//    and out_valid stays 1.
//  - out_ready while empty: ignored.
//  - clr_ovf and a new drop in the same cycle: set wins (overflow=1).
//  - dout while empty: holds the last popped value (0 after reset). Sinks must qualify dout with out_valid.
// STRUCTURE
//  - Package psg_audio_pkg holds:
//      - PSG_SAMPLE_W=11 and AUDIO_W=16 constants;
//      - typedefs psg_sample_t (signed [10:0]) and audio_sample_t (signed [15:0]), shared with the PSG
//        wrapper and the I2S stage.
//  - One sub-module, psg_sample_fifo: a parameterised FWFT FIFO (WIDTH, AW) with push/full/pop/empty/level.
//  - The decimator top holds the accumulator, the counter, the scaling, the push register and the
//    overflow logic.
// TESTING (defaults IN_W=11, OUT_W=16, DECIM_LOG2=8, FIFO_AW=2; in_en every 4th clk)
//  1. din=100 for 256 strobes, out_ready=1 -> single transfer, dout=3200, one cycle after the last strobe.
//  2. din=1023 for 256 strobes -> dout=32736; din=-1024 -> dout=-32768; din=-1 -> dout=-32.
//  3. din alternating +1023/-1024 for 256 strobes -> dout=-16 (sum=-128 >>> 3).
//  4. out_ready=0, 5 blocks of din=7 -> fifo_level=4, overflow=1, FIFO holds 4 x 224.
//     Then out_ready=1 -> 4 transfers of 224, fifo_level returns to 0; clr_ovf pulse -> overflow=0.
//  5. FIFO full, out_ready=1 on the same cycle as a push -> fifo_level stays 4, overflow stays 0.
//     The head pops and the new sample is appended last.
//  6. rst asserted after 100 strobes of din=500, then 256 strobes of din=2 -> one sample, dout=64.
//     No residue from the first partial block; out_valid=0 throughout reset.

Source files
------------

// File: rtl/psg_audio_pkg.sv
// psg_audio_pkg
//   Shared audio-path constants and sample types used by the PSG wrapper,
//   the sample decimator and the I2S stage.
//   PSG_SAMPLE_W : width of the PSG mixed output (signed)
//   AUDIO_W      : width of samples handed to the audio sink (signed)
package psg_audio_pkg;

  localparam int PSG_SAMPLE_W = 11;
  localparam int AUDIO_W      = 16;

  typedef logic signed [PSG_SAMPLE_W-1:0] psg_sample_t;
  typedef logic signed [AUDIO_W-1:0]      audio_sample_t;

endpackage

// File: rtl/psg_sample_fifo.sv
// psg_sample_fifo
//   Small first-word-fall-through FIFO. The head entry is presented on rdata
//   from a register, so rdata holds the last popped value while empty
//   (0 after reset).
//   clk, rst : clock, synchronous active-high reset
//   push     : write request; ignored when full unless a pop occurs that cycle
//   wdata    : data to write
//   pop      : read request; ignored when empty
//   rdata    : head entry
//   full     : 2^AW entries stored
//   empty    : no entries stored
//   level    : number of stored entries, 0..2^AW
module psg_sample_fifo
  import psg_audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_W,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    // Pointers carry one extra wrap bit: same slot, different lap means full.
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level   = wr_ptr_q - rd_ptr_q;
    pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push && (!full || pop_ok);

    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);

    // Next head value: the word being written bypasses the array when it is
    // going to be the head (write into an empty FIFO, or level 1 push+pop).
    rdata_d = rdata_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (push_ok && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/psg_sample_decimator.sv
// psg_sample_decimator
//   Box-car averages 2^DECIM_LOG2 PSG samples into one, left-aligns the
//   average to OUT_W bits and queues it in a FWFT FIFO towards the audio sink.
//   Valid range: IN_W <= OUT_W <= IN_W+DECIM_LOG2, FIFO_AW >= 1.
//   clk, rst   : clock, synchronous active-high reset
//   in_en      : input strobe; din sampled only when high
//   din        : signed PSG sample
//   out_valid  : FIFO head holds a sample
//   out_ready  : sink accepts the head (transfer on out_valid & out_ready)
//   dout       : signed FIFO head sample
//   fifo_level : number of queued samples
//   overflow   : sticky; a finished sample was dropped because the FIFO was full
//   clr_ovf    : clears overflow (a simultaneous new drop wins)
module psg_sample_decimator
  import psg_audio_pkg::*;
#(
  parameter int IN_W       = PSG_SAMPLE_W,
  parameter int OUT_W      = AUDIO_W,
  parameter int DECIM_LOG2 = 8,
  parameter int FIFO_AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_en,
  input  logic signed [IN_W-1:0]  din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  // Sum of 2^DECIM_LOG2 IN_W-bit values always fits in IN_W+DECIM_LOG2 bits.
  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
  logic                    overflow_q, overflow_d;

  logic signed [ACC_W-1:0] sum;
  logic [OUT_W-1:0]        sample;
  logic                    block_done;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_W-1:0]        fifo_rdata;

  always_comb begin
    sum        = acc_q + {{DECIM_LOG2{din[IN_W-1]}}, din};
    // Keeping the top OUT_W bits is an arithmetic right shift of the sum,
    // i.e. the mean scaled to full output range, rounded toward -inf.
    sample     = sum[ACC_W-1 -: OUT_W];
    block_done = in_en && (cnt_q == CNT_LAST);

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_en) begin
      if (block_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + DECIM_LOG2'(1);
      end
    end
  end

  // The finished sample is written straight into the FIFO on the edge that
  // samples the block's last strobe, so it is the head one cycle later.
  always_comb begin
    fifo_pop   = !fifo_empty && out_ready;
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (block_done && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  psg_sample_fifo #(
    .WIDTH (OUT_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (block_done),
    .wdata (sample),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign dout      = fifo_rdata;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_psg_sample_decimator.sv
// tb_psg_sample_decimator
//   Directed bench for psg_sample_decimator at default parameters. Expected
//   samples are queued when a block is issued; a monitor on the falling edge
//   pops and compares on every out_valid & out_ready transfer.
module tb_psg_sample_decimator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_en = 1'b0;
  logic signed [10:0] din = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] dout;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic               clr_ovf = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] exp_q [$];
  logic signed [15:0] mon_exp;

  always #5 clk = ~clk;

  psg_sample_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: inputs change 1 time unit after posedge, so negedge sees them stable.
  always @(negedge clk) begin
    if (rst) begin
      check("valid_in_reset", int'(out_valid), 0);
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_xfer: got dout=%0d, required no transfer", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        check("xfer_dout", int'(dout), int'(mon_exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int v);
    in_en = 1'b1;
    din   = 11'(v);
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  // One block of 256 strobes, one every 4th clock, alternating a/b.
  task automatic run_block(input int a, input int b, input bit lat_chk, input bit ready_last);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        if (lat_chk) check("valid_before_last", int'(out_valid), 0);
        if (ready_last) out_ready = 1'b1;
      end
      strobe((i % 2 == 0) ? a : b);
      if (i == 255) begin
        if (ready_last) out_ready = 1'b0;
        if (lat_chk) check("valid_1_after_last", int'(out_valid), 1);
      end
      idle(3);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || fifo_level != 3'd0) && k < 200) begin
      idle(1);
      k++;
    end
    check("drain_in_time", int'(k < 200), 1);
  endtask

  initial begin
    idle(3);
    check("rst_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    idle(1);

    // Plain averages with the sink always ready
    out_ready = 1'b1;
    exp_q.push_back(16'sd3200);
    run_block(100, 100, 1'b1, 1'b0);
    exp_q.push_back(16'sd32736);
    run_block(1023, 1023, 1'b0, 1'b0);
    exp_q.push_back(-16'sd32768);
    run_block(-1024, -1024, 1'b0, 1'b0);
    exp_q.push_back(-16'sd32);
    run_block(-1, -1, 1'b0, 1'b0);
    exp_q.push_back(-16'sd16);
    run_block(1023, -1024, 1'b0, 1'b0);
    wait_drain();

    // Overflow: five blocks into a four-deep FIFO, fifth is dropped
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(16'sd224);
      run_block(7, 7, 1'b0, 1'b0);
    end
    idle(2);
    check("ovf_level", int'(fifo_level), 4);
    check("ovf_flag", int'(overflow), 1);
    out_ready = 1'b1;
    wait_drain();
    check("ovf_drained_level", int'(fifo_level), 0);
    check("ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Push and pop in the same cycle while full
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(16'(k * 32));
      run_block(k, k, 1'b0, 1'b0);
    end
    check("full_level", int'(fifo_level), 4);
    exp_q.push_back(16'sd160);
    run_block(5, 5, 1'b0, 1'b1);
    idle(2);
    check("pushpop_level", int'(fifo_level), 4);
    check("pushpop_overflow", int'(overflow), 0);
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a block discards the partial sum
    for (int i = 0; i < 100; i++) begin
      strobe(500);
      idle(3);
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_dout", int'(dout), 0);
    idle(1);
    exp_q.push_back(16'sd64);
    run_block(2, 2, 1'b0, 1'b0);
    wait_drain();

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
